weight_pack_loader: RTL and testbench
=====================================

WEIGHT_PACK_LOADER -- requirements
Module: weight_pack_loader

Interface
REQ-001 SHALL have parameters: DATA_W 512 (stream beat width, bits); PACK 16 (beats per buffer word, power of 2, 2..32).
REQ-002 SHALL have parameters: BUF_AW 13 (buffer word address width); NUM_BANKS 2 (buffer banks, power of 2, >=1); ADDR_W 64 (DRAM address width); INST_W 128 (instruction width).
REQ-003 SHALL use clock kernel_clk and reset kernel_rst, asynchronous, active-high.
REQ-004 SHALL have ports:
- kernel_clk  in  1  clock
- kernel_rst  in  1  async active-high reset
- ap_start  in  1  instruction strobe
- ap_done  out  1  one-cycle completion pulse
- ctrl_addr_offset  in  ADDR_W  DRAM base offset
- ctrl_instruction  in  INST_W  load instruction
- rd_start  out  1  one-cycle read-master launch pulse
- rd_addr  out  ADDR_W  DRAM byte address
- rd_size  out  32  transfer size, bytes
- s_tvalid  in  1  stream beat valid
- s_tready  out  1  stream ready
- s_tdata  in  DATA_W  stream beat
- s_tlast  in  1  last beat of transfer
- buf_w_valid  out  1  buffer write enable
- buf_w_bank  out  max(1,log2 NUM_BANKS)  bank select
- buf_w_addr  out  BUF_AW  buffer word address
- buf_w_data  out  PACK*DATA_W  packed buffer word

Function
REQ-005 SHALL decode on accept: buf start [47:32], word count [63:48], bank [64+log2 NUM_BANKS-1:64], byte length [95:80], DRAM address [127:96]; all fields registered.
REQ-006 SHALL implement states IDLE, DECODE, ISSUE, LOAD, DRAIN, DONE; ap_start honoured only in IDLE, ignored in every other state.
REQ-007 SHALL go IDLE->DECODE on ap_start; DECODE->ISSUE, or DECODE->DONE when word count = 0 (no rd_start).
REQ-008 SHALL in ISSUE pulse rd_start for one cycle with rd_addr = ctrl_addr_offset + zero-extended DRAM address (mod 2^ADDR_W), rd_size = zero-extended byte length, both held stable until next accept; then enter LOAD.
REQ-009 SHALL drive s_tready = 1 in LOAD and DRAIN only, 0 otherwise.
REQ-010 SHALL place beat k of a word at bits [k*DATA_W +: DATA_W], k = 0..PACK-1, first beat lowest.
REQ-011 SHALL register a write (buf_w_valid = 1 for one cycle, the cycle after the completing beat) when beat PACK-1 arrives, or when s_tlast arrives mid-word, zero-padding unfilled slices.
REQ-012 SHALL write word n to address (buf start + n) mod 2^BUF_AW, bank from REQ-005, for n = 0..count-1.
REQ-013 SHALL enter DONE after the write of word count-1; if that beat lacks s_tlast, enter DRAIN and discard beats up to and including s_tlast, then DONE.
REQ-014 SHALL enter DONE on s_tlast when fewer than count words written (short transfer), after flushing any partial word.
REQ-015 SHALL pulse ap_done for one cycle in DONE (same cycle as, or after, the final buf_w_valid), then return to IDLE.
REQ-016 SHALL hold buf_w_data/addr/bank stable except on write cycles; buf_w_valid low in all non-write cycles.

Reset
REQ-017 SHALL on kernel_rst force IDLE and drive ap_done, rd_start, s_tready, buf_w_valid to 0 and rd_addr, rd_size, buf_w_addr, buf_w_bank, buf_w_data, internal beat/word counters to 0.
REQ-018 SHALL, on reset mid-LOAD, abandon the transfer with no further writes; stray beats after reset are not accepted (s_tready = 0).

Configuration
REQ-019 SHALL, with WEIGHT_PACK_LOADER_ERR_EN defined, add output err_short (1 bit): set in DONE after a REQ-014 short transfer, sticky, cleared on next accepted ap_start and on reset.
REQ-020 SHALL, without WEIGHT_PACK_LOADER_ERR_EN, omit err_short; behaviour otherwise identical.

Verification
REQ-021 Offset 0x1000, addr 0x40, count 2, len 2048, 32 beats, tlast on 32 -> rd_addr 0x1040, rd_size 2048, writes at start, start+1, then ap_done.
REQ-022 Count 1, 20 beats, tlast on 20 -> one write, 4 beats drained with s_tready = 1, single ap_done after tlast.
REQ-023 Count 3, 20 beats, tlast on 20 -> words 0, 1 (beats 16-19 low, zero-padded), ap_done, err_short = 1 with ERR_EN.
REQ-024 Buf start 0x1FFF, count 2, bank 1 -> addresses 0x1FFF then 0x0000, buf_w_bank 1.
REQ-025 Count 0 -> no rd_start, ap_done 2 cycles after ap_start; ap_start during LOAD ignored.
REQ-026 kernel_rst asserted after 5 beats of LOAD -> all outputs 0, IDLE, no writes; next instruction completes normally.

Source files
------------

// File: rtl/weight_pack_loader.sv
`default_nettype none
// ============================================================================
// Module   : weight_pack_loader
// Purpose  : Decodes a load instruction, launches a DRAM read and packs PACK
//            stream beats per buffer word. Optional macro WEIGHT_PACK_LOADER_ERR_EN
//            adds the sticky err_short output.
// Revision : 1.0 - initial release
// ============================================================================
module weight_pack_loader #(
    parameter int DATA_W    = 512,
    parameter int PACK      = 16,
    parameter int BUF_AW    = 13,
    parameter int NUM_BANKS = 2,
    parameter int ADDR_W    = 64,
    parameter int INST_W    = 128,
    localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                     kernel_clk,
    input  logic                     kernel_rst,
    input  logic                     ap_start,
    output logic                     ap_done,
    input  logic [ADDR_W-1:0]        ctrl_addr_offset,
    input  logic [INST_W-1:0]        ctrl_instruction,
    output logic                     rd_start,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [31:0]              rd_size,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [DATA_W-1:0]        s_tdata,
    input  logic                     s_tlast,
    output logic                     buf_w_valid,
    output logic [BANK_W-1:0]        buf_w_bank,
    output logic [BUF_AW-1:0]        buf_w_addr,
    output logic [PACK*DATA_W-1:0]   buf_w_data
`ifdef WEIGHT_PACK_LOADER_ERR_EN
    ,
    output logic                     err_short
`endif
);

    localparam int BEAT_W = $clog2(PACK);
    localparam int WORD_W = PACK * DATA_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_LOAD   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [BUF_AW-1:0] buf_start_q;
    logic [15:0]       count_q;
    logic [BANK_W-1:0] bank_q;
    logic [15:0]       word_q;
    logic [BEAT_W-1:0] beat_q;
    logic [WORD_W-1:0] pack_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [31:0]       rd_size_q;
    logic              buf_w_valid_q;
    logic [BANK_W-1:0] buf_w_bank_q;
    logic [BUF_AW-1:0] buf_w_addr_q;
    logic [WORD_W-1:0] buf_w_data_q;

    logic              w_accept;
    logic              w_beat_fire;
    logic              w_word_end;
    logic              w_last_word;
    logic [WORD_W-1:0] w_pack;
    logic [BANK_W-1:0] w_inst_bank;
    logic              w_unused_inst;

    generate
        if (NUM_BANKS > 1) begin : g_bank_sel
            assign w_inst_bank = ctrl_instruction[64 +: BANK_W];
        end else begin : g_bank_one
            assign w_inst_bank = 1'b0;
        end
    endgenerate

    assign w_unused_inst = ^ctrl_instruction;

    assign w_accept    = (state_q == S_IDLE) && ap_start;
    assign w_beat_fire = (state_q == S_LOAD) && s_tvalid;
    assign w_word_end  = (beat_q == BEAT_W'(PACK - 1)) || s_tlast;
    assign w_last_word = (word_q == (count_q - 16'd1));

    // Current beat merged into the partially filled word.
    always_comb begin
        w_pack = pack_q;
        w_pack[beat_q*DATA_W +: DATA_W] = s_tdata;
    end

    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (ap_start) state_d = S_DECODE;
            S_DECODE: state_d = (count_q == 16'd0) ? S_DONE : S_ISSUE;
            S_ISSUE:  state_d = S_LOAD;
            S_LOAD: begin
                if (w_beat_fire && w_word_end) begin
                    if (w_last_word) begin
                        state_d = s_tlast ? S_DONE : S_DRAIN;
                    end else if (s_tlast) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DRAIN:  if (s_tvalid && s_tlast) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_start = (state_q == S_ISSUE);
        s_tready = (state_q == S_LOAD) || (state_q == S_DRAIN);
        ap_done  = (state_q == S_DONE);
    end

    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            buf_start_q   <= '0;
            count_q       <= '0;
            bank_q        <= '0;
            word_q        <= '0;
            beat_q        <= '0;
            pack_q        <= '0;
            rd_addr_q     <= '0;
            rd_size_q     <= '0;
            buf_w_valid_q <= 1'b0;
            buf_w_bank_q  <= '0;
            buf_w_addr_q  <= '0;
            buf_w_data_q  <= '0;
        end else begin
            buf_w_valid_q <= 1'b0;
            if (w_accept) begin
                buf_start_q <= ctrl_instruction[32 +: BUF_AW];
                count_q     <= ctrl_instruction[63:48];
                bank_q      <= w_inst_bank;
                rd_addr_q   <= ctrl_addr_offset + ADDR_W'(ctrl_instruction[127:96]);
                rd_size_q   <= 32'(ctrl_instruction[95:80]);
                word_q      <= '0;
                beat_q      <= '0;
                pack_q      <= '0;
            end
            if (w_beat_fire) begin
                if (w_word_end) begin
                    // Unfilled slices stay zero because pack_q is cleared per word.
                    buf_w_valid_q <= 1'b1;
                    buf_w_data_q  <= w_pack;
                    buf_w_addr_q  <= buf_start_q + word_q[BUF_AW-1:0];
                    buf_w_bank_q  <= bank_q;
                    pack_q        <= '0;
                    beat_q        <= '0;
                    word_q        <= word_q + 16'd1;
                end else begin
                    pack_q <= w_pack;
                    beat_q <= beat_q + BEAT_W'(1);
                end
            end
        end
    end

`ifdef WEIGHT_PACK_LOADER_ERR_EN
    logic err_short_q;

    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            err_short_q <= 1'b0;
        end else if (w_accept) begin
            err_short_q <= 1'b0;
        end else if (w_beat_fire && s_tlast && !w_last_word) begin
            err_short_q <= 1'b1;
        end
    end

    assign err_short = err_short_q;
`endif

    assign rd_addr     = rd_addr_q;
    assign rd_size     = rd_size_q;
    assign buf_w_valid = buf_w_valid_q;
    assign buf_w_bank  = buf_w_bank_q;
    assign buf_w_addr  = buf_w_addr_q;
    assign buf_w_data  = buf_w_data_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_pack_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_pack_loader
// Purpose  : Directed and randomized transfers against a word-packing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_pack_loader;

    localparam int DW  = 16;
    localparam int PK  = 16;
    localparam int AW  = 13;
    localparam int NB  = 2;
    localparam int ADW = 64;
    localparam int IW  = 128;
    localparam int WW  = PK * DW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ap_start = 1'b0;
    logic            ap_done;
    logic [ADW-1:0]  offset = '0;
    logic [IW-1:0]   instr = '0;
    logic            rd_start;
    logic [ADW-1:0]  rd_addr;
    logic [31:0]     rd_size;
    logic            s_tvalid = 1'b0;
    logic            s_tready;
    logic [DW-1:0]   s_tdata = '0;
    logic            s_tlast = 1'b0;
    logic            buf_w_valid;
    logic [0:0]      buf_w_bank;
    logic [AW-1:0]   buf_w_addr;
    logic [WW-1:0]   buf_w_data;
`ifdef WEIGHT_PACK_LOADER_ERR_EN
    logic            err_short;
`endif

    weight_pack_loader #(
        .DATA_W(DW), .PACK(PK), .BUF_AW(AW), .NUM_BANKS(NB), .ADDR_W(ADW), .INST_W(IW)
    ) dut (
        .kernel_clk(clk), .kernel_rst(rst),
        .ap_start(ap_start), .ap_done(ap_done),
        .ctrl_addr_offset(offset), .ctrl_instruction(instr),
        .rd_start(rd_start), .rd_addr(rd_addr), .rd_size(rd_size),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .buf_w_valid(buf_w_valid), .buf_w_bank(buf_w_bank),
        .buf_w_addr(buf_w_addr), .buf_w_data(buf_w_data)
`ifdef WEIGHT_PACK_LOADER_ERR_EN
        , .err_short(err_short)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] wq_a[$];
    logic          wq_b[$];
    logic [WW-1:0] wq_d[$];
    int            rs_cnt = 0;
    logic [ADW-1:0] rs_addr;
    logic [31:0]   rs_size;
    int            done_cnt = 0;
    int            writes_at_done = 0;

    always @(negedge clk) begin
        if (buf_w_valid) begin
            wq_a.push_back(buf_w_addr);
            wq_b.push_back(buf_w_bank[0]);
            wq_d.push_back(buf_w_data);
        end
        if (rd_start) begin
            rs_cnt++;
            rs_addr = rd_addr;
            rs_size = rd_size;
        end
        if (ap_done) begin
            done_cnt++;
            writes_at_done = wq_d.size();
        end
    end

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk_instr(input logic [31:0] addr, input logic [15:0] start,
                                               input logic [15:0] count, input logic bank,
                                               input logic [15:0] len);
        logic [IW-1:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        v[47:32]  = start;
        v[63:48]  = count;
        v[64]     = bank;
        v[95:80]  = len;
        v[127:96] = addr;
        return v;
    endfunction

    task automatic run(input logic [ADW-1:0] off, input logic [31:0] addr, input logic [15:0] start,
                       input int count, input logic bank, input logic [15:0] len,
                       input int nbeats, input bit poke);
        logic [DW-1:0] beats[$];
        logic [WW-1:0] exp_d;
        int i, g, nexp, nfull, b;
        bit short;
        wq_a.delete(); wq_b.delete(); wq_d.delete();
        rs_cnt = 0; done_cnt = 0; writes_at_done = 0;
        for (int k = 0; k < nbeats; k++) beats.push_back(DW'($urandom));

        @(negedge clk);
        offset   = off;
        instr    = mk_instr(addr, start, 16'(count), bank, len);
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        if (count == 0) begin
            check("done_early", ap_done, 1'b0);
            @(negedge clk);
            check("done_latency", ap_done, 1'b1);
        end

        i = 0; g = 0;
        while (i < nbeats && g < 2000) begin
            @(negedge clk);
            g++;
            ap_start = (poke && i == 2);
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata  = beats[i];
            s_tlast  = (i == nbeats - 1);
            if (s_tvalid && s_tready) i++;
        end
        check("beats_accepted", i, nbeats);
        @(negedge clk);
        s_tvalid = 1'b0; s_tlast = 1'b0; ap_start = 1'b0;
        g = 0;
        while (done_cnt == 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        repeat (4) @(negedge clk);

        nfull = (nbeats + PK - 1) / PK;
        nexp  = (nfull < count) ? nfull : count;
        short = (nfull < count);
        check("done_count", done_cnt, 1);
        check("rd_start_count", rs_cnt, (count == 0) ? 0 : 1);
        if (count != 0) begin
            check("rd_addr", rs_addr, off + {32'd0, addr});
            check("rd_size", rs_size, {16'd0, len});
        end
        check("write_count", wq_d.size(), nexp);
        check("writes_before_done", writes_at_done, nexp);
        for (int n = 0; n < nexp && n < wq_d.size(); n++) begin
            exp_d = '0;
            for (int k = 0; k < PK; k++) begin
                b = n * PK + k;
                if (b < nbeats) exp_d[k*DW +: DW] = beats[b];
            end
            check("w_addr", wq_a[n], AW'(start + 16'(n)));
            check("w_bank", wq_b[n], bank);
            check("w_data", wq_d[n], exp_d);
        end
`ifdef WEIGHT_PACK_LOADER_ERR_EN
        check("err_short", err_short, short);
`else
        if (short) total = total + 0;
`endif
    endtask

    initial begin
        int i, g;
        repeat (3) @(negedge clk);
        check("rst_ap_done", ap_done, 1'b0);
        check("rst_rd_start", rd_start, 1'b0);
        check("rst_tready", s_tready, 1'b0);
        check("rst_wvalid", buf_w_valid, 1'b0);
        check("rst_rd_addr", rd_addr, '0);
        check("rst_w_data", buf_w_data, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(64'h1000, 32'h40, 16'h0100, 2, 1'b0, 16'd2048, 32, 1'b0);
        run(64'h2000, 32'h80, 16'h0010, 1, 1'b0, 16'd1280, 20, 1'b0);
        run(64'h0, 32'h100, 16'h0020, 3, 1'b1, 16'd1280, 20, 1'b0);
        run(64'h0, 32'h0, 16'h1FFF, 2, 1'b1, 16'd2048, 32, 1'b0);
        run(64'h0, 32'h0, 16'h0005, 0, 1'b0, 16'd0, 0, 1'b0);
        run(64'h3000, 32'h10, 16'h0040, 2, 1'b0, 16'd2048, 32, 1'b1);

        // Reset in the middle of a transfer.
        wq_d.delete(); done_cnt = 0;
        @(negedge clk);
        instr = mk_instr(32'h200, 16'h0300, 16'd2, 1'b0, 16'd2048);
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        i = 0; g = 0;
        while (i < 5 && g < 500) begin
            @(negedge clk);
            g++;
            s_tvalid = 1'b1;
            s_tdata  = DW'($urandom);
            if (s_tready) i++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_tready", s_tready, 1'b0);
        check("mid_rst_wvalid", buf_w_valid, 1'b0);
        check("mid_rst_rd_addr", rd_addr, '0);
        check("mid_rst_rd_size", rd_size, '0);
        check("mid_rst_w_addr", buf_w_addr, '0);
        check("mid_rst_w_data", buf_w_data, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_tready", s_tready, 1'b0);
        check("post_rst_writes", wq_d.size(), 0);
        check("post_rst_done", done_cnt, 0);
        s_tvalid = 1'b0;
        run(64'h40, 32'h8, 16'h0700, 2, 1'b1, 16'd2048, 32, 1'b0);

        for (int r = 0; r < 5; r++) begin
            run({$urandom, $urandom}, $urandom, 16'($urandom_range(0, 8191)),
                $urandom_range(1, 3), 1'($urandom), 16'($urandom), $urandom_range(1, 56), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
